// File: rtl/rgmii_rx_frame_ctrl.sv
// RGMII receive frame sequencer: decodes RX_DV/RX_ER, strips preamble/SFD and emits
// a delimited byte stream with sof/eof/err markers plus good/bad frame counters.
module rgmii_rx_frame_ctrl #(
  parameter int unsigned PRE_MIN = 1,
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             rxck_i,
  input  logic             rst_i,
  input  logic [7:0]       rxd_i,
  input  logic             rxctl_lo_i,
  input  logic             rxctl_hi_i,
  input  logic             enable_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic             err_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int unsigned LenW = $clog2(MAX_LEN + 2);
  localparam int unsigned PreW = $clog2(PRE_MIN + 2);
  localparam logic [LenW-1:0] LenSat = LenW'(MAX_LEN + 1);
  localparam logic [LenW-1:0] LenMin = LenW'(MIN_LEN);
  localparam logic [LenW-1:0] LenMax = LenW'(MAX_LEN);
  localparam logic [PreW-1:0] PreSat = PreW'(PRE_MIN);

  typedef enum logic [1:0] {StIdle, StPre, StPay, StDrop} state_e;

  state_e          state_q;
  logic [PreW-1:0] pre_cnt_q;
  logic [LenW-1:0] len_q;
  logic [7:0]      hold_q;
  logic            err_flag_q;
  logic            first_q;

  logic dv, er, eof_err;

  assign dv      = rxctl_lo_i;
  assign er      = rxctl_lo_i ^ rxctl_hi_i;
  assign eof_err = err_flag_q | (len_q < LenMin) | (len_q > LenMax);
  assign busy_o  = (state_q != StIdle);

  // The hold byte is occupied whenever len_q != 0, so the last byte can be tagged with
  // eof once dv drops.
  always_ff @(posedge rxck_i) begin
    if (rst_i) begin
      state_q     <= StDrop;
      pre_cnt_q   <= '0;
      len_q       <= '0;
      hold_q      <= '0;
      err_flag_q  <= 1'b0;
      first_q     <= 1'b0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      sof_o       <= 1'b0;
      eof_o       <= 1'b0;
      err_o       <= 1'b0;
      frame_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      valid_o <= 1'b0;
      sof_o   <= 1'b0;
      eof_o   <= 1'b0;
      err_o   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (dv) begin
            if (enable_i && rxd_i == 8'h55) begin
              state_q   <= StPre;
              pre_cnt_q <= PreW'(1);
            end else begin
              state_q <= StDrop;
            end
          end
        end
        StPre: begin
          if (!dv) begin
            state_q <= StIdle;
          end else if (er) begin
            state_q <= StDrop;
          end else if (rxd_i == 8'h55) begin
            if (pre_cnt_q < PreSat) pre_cnt_q <= pre_cnt_q + PreW'(1);
          end else if (rxd_i == 8'hD5 && pre_cnt_q >= PreSat) begin
            state_q    <= StPay;
            len_q      <= '0;
            err_flag_q <= 1'b0;
            first_q    <= 1'b1;
          end else begin
            state_q <= StDrop;
          end
        end
        StPay: begin
          if (dv) begin
            hold_q <= rxd_i;
            if (len_q != LenSat) len_q <= len_q + LenW'(1);
            if (er) err_flag_q <= 1'b1;
            if (len_q != '0) begin
              valid_o <= 1'b1;
              data_o  <= hold_q;
              sof_o   <= first_q;
              first_q <= 1'b0;
            end
          end else begin
            state_q <= StIdle;
            first_q <= 1'b0;
            if (len_q != '0) begin
              valid_o <= 1'b1;
              data_o  <= hold_q;
              sof_o   <= first_q;
              eof_o   <= 1'b1;
              err_o   <= eof_err;
              if (eof_err) err_cnt_o <= err_cnt_o + CNT_W'(1);
              else         frame_cnt_o <= frame_cnt_o + CNT_W'(1);
            end else begin
              err_cnt_o <= err_cnt_o + CNT_W'(1);
            end
          end
        end
        StDrop: begin
          if (!dv) state_q <= StIdle;
        end
        default: state_q <= StDrop;
      endcase
    end
  end

endmodule
